// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses ASCII "wFPGA,<A>,<D>\n" / "rFPGA,<A>\n" into bus strobes
// and returns read data as a decimal ASCII line (or "ERR\n" on malformed input).
module uart_cmd_bridge #(
   parameter int unsigned AddrWidth = 16,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_valid_i,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic [AddrWidth-1:0] address_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 we_o,
   output logic                 rd_o,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 halt_i,
   output logic                 busy_o,
   output logic                 overrun_o
);

   if (DataWidth != 32) begin : gen_cfg_err
      $error("uart_cmd_bridge: DataWidth must be 32");
   end

   localparam logic [7:0] ChNl    = 8'h0a;
   localparam logic [7:0] ChCr    = 8'h0d;
   localparam logic [7:0] ChComma = 8'h2c;

   typedef enum logic [3:0] {
      StIdle, StPrefix, StArgA, StArgD, StBusWr, StBusRd,
      StRdWait, StConvert, StSend, StDiscard, StErrSend
   } state_e;

   state_e                 state_q, state_d;
   logic                   is_wr_q, is_wr_d;
   logic [2:0]             pfx_q, pfx_d;
   logic [31:0]            acc_q, acc_d;
   logic                   seen_q, seen_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rem_q, rem_d;
   logic [3:0]             pow_q, pow_d;
   logic [3:0]             digit_q, digit_d;
   logic                   lead_q, lead_d;
   logic [7:0]             rsp_buf_q [11];
   logic [7:0]             rsp_buf_d [11];
   logic [3:0]             len_q, len_d;
   logic [3:0]             tx_idx_q, tx_idx_d;
   logic                   overrun_q, overrun_d;

   logic                   is_digit;
   logic [31:0]            acc_next;
   logic [31:0]            pow_val;
   state_e                 err_target;

   function automatic logic [7:0] prefix_char(input logic [2:0] idx);
      case (idx)
         3'd0:    prefix_char = 8'h46;  // F
         3'd1:    prefix_char = 8'h50;  // P
         3'd2:    prefix_char = 8'h47;  // G
         3'd3:    prefix_char = 8'h41;  // A
         default: prefix_char = 8'h2c;  // ,
      endcase
   endfunction

   function automatic logic [31:0] pow10(input logic [3:0] idx);
      case (idx)
         4'd0:    pow10 = 32'd1000000000;
         4'd1:    pow10 = 32'd100000000;
         4'd2:    pow10 = 32'd10000000;
         4'd3:    pow10 = 32'd1000000;
         4'd4:    pow10 = 32'd100000;
         4'd5:    pow10 = 32'd10000;
         4'd6:    pow10 = 32'd1000;
         4'd7:    pow10 = 32'd100;
         4'd8:    pow10 = 32'd10;
         default: pow10 = 32'd1;
      endcase
   endfunction

   assign is_digit   = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
   assign acc_next   = acc_q * 32'd10 + {28'd0, rx_data_i[3:0]};
   assign pow_val    = pow10(pow_q);
   assign err_target = (rx_data_i == ChNl) ? StErrSend : StDiscard;

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      pfx_d     = pfx_q;
      acc_d     = acc_q;
      seen_d    = seen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rem_d     = rem_q;
      pow_d     = pow_q;
      digit_d   = digit_q;
      lead_d    = lead_q;
      rsp_buf_d = rsp_buf_q;
      len_d     = len_q;
      tx_idx_d  = tx_idx_q;
      overrun_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rx_valid_i && rx_data_i != ChNl && rx_data_i != ChCr) begin
               if (rx_data_i == 8'h77 || rx_data_i == 8'h72) begin
                  is_wr_d = (rx_data_i == 8'h77);
                  pfx_d   = 3'd0;
                  acc_d   = '0;
                  seen_d  = 1'b0;
                  state_d = StPrefix;
               end else begin
                  state_d = StDiscard;
               end
            end
         end
         StPrefix: begin
            if (rx_valid_i && rx_data_i != ChCr) begin
               if (rx_data_i == prefix_char(pfx_q)) begin
                  pfx_d = pfx_q + 3'd1;
                  if (pfx_q == 3'd4) state_d = StArgA;
               end else begin
                  state_d = err_target;
               end
            end
         end
         StArgA: begin
            if (rx_valid_i && rx_data_i != ChCr) begin
               if (is_digit) begin
                  acc_d  = acc_next;
                  seen_d = 1'b1;
               end else if (seen_q && is_wr_q && rx_data_i == ChComma) begin
                  addr_d  = acc_q[AddrWidth-1:0];
                  acc_d   = '0;
                  seen_d  = 1'b0;
                  state_d = StArgD;
               end else if (seen_q && !is_wr_q && rx_data_i == ChNl) begin
                  addr_d  = acc_q[AddrWidth-1:0];
                  state_d = StBusRd;
               end else begin
                  state_d = err_target;
               end
            end
         end
         StArgD: begin
            if (rx_valid_i && rx_data_i != ChCr) begin
               if (is_digit) begin
                  acc_d  = acc_next;
                  seen_d = 1'b1;
               end else if (seen_q && rx_data_i == ChNl) begin
                  wdata_d = acc_q;
                  state_d = StBusWr;
               end else begin
                  state_d = err_target;
               end
            end
         end
         StDiscard: begin
            if (rx_valid_i && rx_data_i == ChNl) state_d = StErrSend;
         end
         StBusWr: begin
            if (!halt_i) state_d = StIdle;
         end
         StBusRd: begin
            if (!halt_i) state_d = StRdWait;
         end
         StRdWait: begin
            rem_d   = data_i;
            pow_d   = 4'd0;
            digit_d = 4'd0;
            lead_d  = 1'b0;
            len_d   = 4'd0;
            state_d = StConvert;
         end
         StConvert: begin
            // One subtraction per cycle; a failed compare closes the current digit position.
            if (rem_q >= pow_val) begin
               rem_d   = rem_q - pow_val;
               digit_d = digit_q + 4'd1;
            end else begin
               digit_d = 4'd0;
               if (digit_q != 4'd0 || lead_q || pow_q == 4'd9) begin
                  rsp_buf_d[len_q] = 8'h30 + {4'd0, digit_q};
                  len_d            = len_q + 4'd1;
                  lead_d           = 1'b1;
               end
               if (pow_q == 4'd9) begin
                  rsp_buf_d[len_q + 4'd1] = ChNl;
                  len_d                   = len_q + 4'd2;
                  state_d                 = StSend;
               end else begin
                  pow_d = pow_q + 4'd1;
               end
            end
         end
         StSend: begin
            if (tx_ready_i) begin
               if (tx_idx_q == len_q - 4'd1) state_d = StIdle;
               else tx_idx_d = tx_idx_q + 4'd1;
            end
         end
         StErrSend: begin
            if (tx_ready_i) begin
               if (tx_idx_q == 4'd3) state_d = StIdle;
               else tx_idx_d = tx_idx_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_d != StSend && state_d != StErrSend) tx_idx_d = '0;

      // Bytes arriving while the bridge is executing or responding are dropped.
      if (rx_valid_i && (state_q == StBusWr || state_q == StBusRd || state_q == StRdWait ||
                         state_q == StConvert || state_q == StSend || state_q == StErrSend)) begin
         overrun_d = 1'b1;
      end
   end

   always_comb begin
      tx_data_o = '0;
      if (state_q == StSend) begin
         tx_data_o = rsp_buf_q[tx_idx_q];
      end else if (state_q == StErrSend) begin
         case (tx_idx_q[1:0])
            2'd0:    tx_data_o = 8'h45;  // E
            2'd1:    tx_data_o = 8'h52;  // R
            2'd2:    tx_data_o = 8'h52;  // R
            default: tx_data_o = ChNl;
         endcase
      end
   end

   assign tx_valid_o = (state_q == StSend) || (state_q == StErrSend);
   assign we_o       = (state_q == StBusWr);
   assign rd_o       = (state_q == StBusRd);
   assign busy_o     = (state_q != StIdle);
   assign overrun_o  = overrun_q;
   assign address_o  = addr_q;
   assign data_o     = wdata_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         is_wr_q   <= 1'b0;
         pfx_q     <= '0;
         acc_q     <= '0;
         seen_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rem_q     <= '0;
         pow_q     <= '0;
         digit_q   <= '0;
         lead_q    <= 1'b0;
         rsp_buf_q <= '{default: '0};
         len_q     <= '0;
         tx_idx_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         pfx_q     <= pfx_d;
         acc_q     <= acc_d;
         seen_q    <= seen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rem_q     <= rem_d;
         pow_q     <= pow_d;
         digit_q   <= digit_d;
         lead_q    <= lead_d;
         rsp_buf_q <= rsp_buf_d;
         len_q     <= len_d;
         tx_idx_q  <= tx_idx_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameter AddrWidth, default 16; width of the bus address.
REQ-002 Parameter DataWidth, default 32; fixed at 32, any other value is a configuration error.
REQ-003 clk_i  in  1  single system clock; all logic on rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 rx_data_i  in  8  received UART byte.
REQ-006 rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i; no backpressure.
REQ-007 tx_data_o  out  8  response byte to the UART transmitter.
REQ-008 tx_valid_o  out  1  tx_data_o valid; held with stable data until accepted.
REQ-009 tx_ready_i  in  1  transmitter accepts the byte on a cycle where tx_valid_o and tx_ready_i are both high.
REQ-010 address_o  out  AddrWidth  bus address.
REQ-011 data_o  out  32  bus write data.
REQ-012 we_o  out  1  bus write strobe.
REQ-013 rd_o  out  1  bus read strobe.
REQ-014 data_i  in  32  bus read data, valid the cycle after read acceptance.
REQ-015 halt_i  in  1  bus stall; a strobe is accepted only on a cycle where halt_i is low.
REQ-016 busy_o  out  1  high in every state other than IDLE.
REQ-017 overrun_o  out  1  one-cycle pulse when an rx byte is dropped.

Function
REQ-018 Command grammar: "wFPGA,<A>,<D>\n" (write) and "rFPGA,<A>\n" (read); <A> and <D> are unsigned decimal; '\r' is ignored in all parsing states.
REQ-019 States: IDLE, PREFIX, ARG_A, ARG_D, BUS_WR, BUS_RD, RD_WAIT, CONVERT, SEND, DISCARD, ERR_SEND.
REQ-020 IDLE: 'w' or 'r' latches the opcode and goes to PREFIX; '\n' is ignored and stays in IDLE; any other byte goes to DISCARD.
REQ-021 PREFIX: the next bytes shall match "FPGA," exactly; on full match go to ARG_A; on first mismatch go to DISCARD, or to ERR_SEND if the mismatching byte is '\n'.
REQ-022 Argument accumulation: on each digit, acc <= acc*10 + digit, truncated modulo 2^32; more than 10 digits wraps silently.
REQ-023 Address taken as acc[AddrWidth-1:0]; upper bits are discarded.
REQ-024 ARG_A terminators: ',' on a write goes to ARG_D; '\n' on a read goes to BUS_RD.
REQ-025 ARG_D terminator: '\n' goes to BUS_WR.
REQ-026 Argument errors: an empty argument, a non-digit, or a wrong terminator is an error; go to ERR_SEND if the byte is '\n', else to DISCARD.
REQ-027 DISCARD: drop bytes until '\n', then go to ERR_SEND.
REQ-028 BUS_WR: drive address_o, data_o and we_o=1 until a cycle with halt_i=0; on that cycle the write completes; return to IDLE with no UART response.
REQ-029 BUS_RD: drive address_o and rd_o=1 until a cycle with halt_i=0; go to RD_WAIT; capture data_i on the next cycle; go to CONVERT.
REQ-030 CONVERT: binary-to-decimal by repeated subtraction of 10^9 down to 10^0; at most 9 subtractions per digit position, one per cycle.
REQ-031 CONVERT output: digits go to an 11-byte buffer with leading zeros suppressed; value 0 produces "0"; buffer terminated by '\n'.
REQ-032 CONVERT latency: at most 100 cycles.
REQ-033 SEND: emit buffer bytes in order under the valid/ready handshake; after '\n' is accepted, go to IDLE.
REQ-034 ERR_SEND: emit "ERR\n" under the same handshake, then go to IDLE.
REQ-035 Drops: rx_valid_i in BUS_WR, BUS_RD, RD_WAIT, CONVERT, SEND or ERR_SEND drops the byte and pulses overrun_o; the parser state is unaffected.
REQ-036 Strobe hold: we_o and rd_o shall never be high simultaneously; address_o and data_o stay stable while a strobe is held.

Reset
REQ-037 Reset values: state IDLE; tx_valid_o=0, we_o=0, rd_o=0, busy_o=0, overrun_o=0.
REQ-038 Reset values: address_o, data_o, tx_data_o, accumulators and buffer = 0.
REQ-039 Reset mid-operation, including during a held strobe or a pending tx byte, aborts within one cycle with no further strobes or bytes.

Verification
REQ-040 "wFPGA,36868,305419896\n" with halt_i=0 -> exactly one cycle of we_o=1, address_o=0x9004, data_o=0x12345678; no tx bytes.
REQ-041 "rFPGA,36864\n" with data_i=4294967295 -> one rd_o cycle at 0x9000; tx bytes "4294967295\n"; data_i=0 -> tx bytes "0\n".
REQ-042 Write with halt_i high for 7 cycles -> we_o held 8 cycles with stable address_o and data_o; exactly one completion.
REQ-043 "xFPGA,1\n" and "rFPGA,\n" -> each produces "ERR\n" and no bus strobe; a lone "\n" produces nothing.
REQ-044 tx_ready_i toggling pseudo-randomly during a read response -> byte sequence intact; bytes sent during SEND -> dropped with an overrun_o pulse for each.
REQ-045 Reset asserted mid-SEND -> tx_valid_o=0 on the next cycle; a following valid command executes normally.
